// File: rtl/pwm_playback_mc.sv
// pwm_playback_mc: multi-channel PWM sample player with per-frame shadow prefetch.
// Define PWM_PLAYBACK_LOOP_EN to let loop_en repeat the buffer.
module pwm_playback_mc #(
    parameter int CLK_FREQ    = 100,
    parameter int INPUT_FREQ  = 24000,
    parameter int SAMPLE_BITS = 7,
    parameter int NUM_CH      = 2,
    parameter int RAM_SIZE    = 16384
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_playback,
    input  logic                        stop_playback,
    input  logic                        loop_en,
    output logic [$clog2(RAM_SIZE)-1:0] ram_rdaddr,
    input  logic [SAMPLE_BITS:0]        ram_sample,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 clr_led
);
    localparam int AW = $clog2(RAM_SIZE);
    localparam int SW = SAMPLE_BITS + 1;
    localparam int CLK_COUNT = int'((64'(CLK_FREQ) * 64'd1000000)
                                    / (64'(INPUT_FREQ) << SAMPLE_BITS));
    localparam int TW = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;
    localparam int FRAMES = RAM_SIZE / NUM_CH;
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SAMPLE_BITS-1:0] PH_MAX = '1;

    if (CLK_COUNT < NUM_CH + 2) begin : g_clk_count_check
        $error("pwm_playback_mc: CLK_COUNT must be at least NUM_CH+2");
    end

    typedef enum logic [1:0] {IDLE, PREFETCH, PLAY} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [SAMPLE_BITS-1:0] phase_q, phase_d;
    logic                   playing_q, playing_d;
    logic [FW-1:0]          cur_frame_q, cur_frame_d;
    logic                   stop_pend_q, stop_pend_d;
    logic [AW-1:0]          rdaddr_q, rdaddr_d;
    logic                   fetch_q, fetch_d;
    logic [CW-1:0]          fch_q, fch_d;
    logic                   cap_q, cap_d;
    logic [CW-1:0]          cap_ch_q, cap_ch_d;
    logic                   done_q, done_d;
    logic [15:0]            led_q, led_d;
    logic [SW-1:0]          shadow_q [NUM_CH];
    logic [SW-1:0]          shadow_d [NUM_CH];
    logic [SW-1:0]          amp_q [NUM_CH];
    logic [SW-1:0]          amp_d [NUM_CH];
    logic [3:0]             start_sync_q, start_sync_d;
    logic [3:0]             stop_sync_q, stop_sync_d;

    logic          start_edge, stop_edge, stop_now, tick;
    logic          last_frame, loop_eff;
    logic [FW-1:0] next_frame;
    logic [AW+3:0] addr_pad;
    logic [3:0]    led_idx;

`ifdef PWM_PLAYBACK_LOOP_EN
    assign loop_eff = loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
    assign loop_eff = 1'b0;
`endif

    always_comb begin
        start_sync_d = {start_sync_q[2:0], start_playback};
        stop_sync_d  = {stop_sync_q[2:0], stop_playback};
        start_edge   = start_sync_q[2] & ~start_sync_q[3];
        stop_edge    = stop_sync_q[2] & ~stop_sync_q[3];
        stop_now     = stop_pend_q | stop_edge;
        tick         = (tick_q == TW'(CLK_COUNT - 1));
        tick_d       = tick ? '0 : tick_q + 1'b1;
        last_frame   = (cur_frame_q == FW'(FRAMES - 1));
        next_frame   = '0;
        if (playing_q && !last_frame)
            next_frame = cur_frame_q + 1'b1;
        addr_pad     = {rdaddr_q, 4'b0000};
        led_idx      = ~addr_pad[AW+3:AW];

        state_d     = state_q;
        phase_d     = phase_q;
        playing_d   = playing_q;
        cur_frame_d = cur_frame_q;
        stop_pend_d = stop_pend_q;
        rdaddr_d    = rdaddr_q;
        fetch_d     = fetch_q;
        fch_d       = fch_q;
        cap_d       = fetch_q;
        cap_ch_d    = fch_q;
        done_d      = 1'b0;
        led_d       = '0;
        shadow_d    = shadow_q;
        amp_d       = amp_q;

        // One read per clock; data is captured a cycle later.
        if (fetch_q) begin
            rdaddr_d = rdaddr_q + 1'b1;
            if (fch_q == CW'(NUM_CH - 1))
                fetch_d = 1'b0;
            else
                fch_d = fch_q + 1'b1;
        end
        if (cap_q)
            shadow_d[cap_ch_q] = ram_sample;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = PREFETCH;
                    rdaddr_d    = '0;
                    fetch_d     = 1'b1;
                    fch_d       = '0;
                    cur_frame_d = '0;
                    playing_d   = 1'b0;
                    phase_d     = '0;
                    stop_pend_d = 1'b0;
                end
            end
            PREFETCH: begin
                if (stop_edge)
                    stop_pend_d = 1'b1;
                if (cap_q && cap_ch_q == CW'(NUM_CH - 1))
                    state_d = PLAY;
            end
            PLAY: begin
                if (stop_edge)
                    stop_pend_d = 1'b1;
                if (tick) begin
                    if (playing_q && phase_q != PH_MAX) begin
                        phase_d = phase_q + 1'b1;
                    end else if (stop_now
                                 || (playing_q && last_frame && !loop_eff)) begin
                        state_d     = IDLE;
                        playing_d   = 1'b0;
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        playing_d        = 1'b1;
                        phase_d          = '0;
                        amp_d            = shadow_q;
                        led_d[led_idx]   = 1'b1;
                        cur_frame_d      = next_frame;
                        // Skip the fetch when this frame is the final one.
                        if (loop_eff || next_frame != FW'(FRAMES - 1)) begin
                            fetch_d = 1'b1;
                            fch_d   = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            phase_q      <= '0;
            playing_q    <= 1'b0;
            cur_frame_q  <= '0;
            stop_pend_q  <= 1'b0;
            rdaddr_q     <= '0;
            fetch_q      <= 1'b0;
            fch_q        <= '0;
            cap_q        <= 1'b0;
            cap_ch_q     <= '0;
            done_q       <= 1'b0;
            led_q        <= '0;
            shadow_q     <= '{default: '0};
            amp_q        <= '{default: '0};
            start_sync_q <= '0;
            stop_sync_q  <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            phase_q      <= phase_d;
            playing_q    <= playing_d;
            cur_frame_q  <= cur_frame_d;
            stop_pend_q  <= stop_pend_d;
            rdaddr_q     <= rdaddr_d;
            fetch_q      <= fetch_d;
            fch_q        <= fch_d;
            cap_q        <= cap_d;
            cap_ch_q     <= cap_ch_d;
            done_q       <= done_d;
            led_q        <= led_d;
            shadow_q     <= shadow_d;
            amp_q        <= amp_d;
            start_sync_q <= start_sync_d;
            stop_sync_q  <= stop_sync_d;
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (state_q == PLAY && playing_q)
                pwm_out[c] = ({1'b0, phase_q} < amp_q[c]);
    end

    assign ram_rdaddr = rdaddr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign clr_led    = led_q;
endmodule

// File: tb/tb_pwm_playback_mc.sv
// tb_pwm_playback_mc: directed scoreboard bench for pwm_playback_mc.
// Small configuration: 8 ticks/frame, 2 channels, 16-entry RAM.
module tb_pwm_playback_mc;
    localparam int CC    = (100 * 1000000) / (24000 * 8);
    localparam int FRAME = 8 * CC;

    typedef struct {
        int led;
        int hi0;
        int hi1;
        int len;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_playback;
    logic       stop_playback;
    logic       loop_en;
    logic [3:0] ram_rdaddr;
    logic [3:0] ram_sample;
    logic [1:0] pwm_out;
    logic       busy;
    logic       done;
    logic [15:0] clr_led;

    logic [3:0] mem [16];
    frm_t exp_q[$];
    frm_t obs_q[$];
    frm_t cur;
    bit   in_frm = 1'b0;
    int   done_cnt = 0;
    int   total = 0;
    int   bad = 0;

    pwm_playback_mc #(
        .CLK_FREQ(100), .INPUT_FREQ(24000), .SAMPLE_BITS(3),
        .NUM_CH(2), .RAM_SIZE(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_playback(start_playback), .stop_playback(stop_playback),
        .loop_en(loop_en), .ram_rdaddr(ram_rdaddr), .ram_sample(ram_sample),
        .pwm_out(pwm_out), .busy(busy), .done(done), .clr_led(clr_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_sample <= mem[ram_rdaddr];

    function automatic int led_of(input logic [15:0] v);
        int r = -1;
        if ($countones(v) == 1)
            for (int i = 0; i < 16; i++)
                if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_frm = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt = done_cnt + 1;
            if (in_frm && (clr_led !== 16'h0 || busy !== 1'b1)) begin
                obs_q.push_back(cur);
                in_frm = 1'b0;
            end
            if (clr_led !== 16'h0) begin
                in_frm  = 1'b1;
                cur.led = led_of(clr_led);
                cur.hi0 = 0;
                cur.hi1 = 0;
                cur.len = 0;
            end
            if (in_frm) begin
                cur.len = cur.len + 1;
                cur.hi0 = cur.hi0 + int'(pwm_out[0] === 1'b1);
                cur.hi1 = cur.hi1 + int'(pwm_out[1] === 1'b1);
            end
        end
    end

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic fill(input logic [3:0] a0, input logic [3:0] a1);
        for (int i = 0; i < 8; i++) begin
            mem[2*i]   = a0;
            mem[2*i+1] = a1;
        end
    endtask

    task automatic push_frm(input int n, input int a0, input int a1);
        frm_t e;
        e.led = 15 - ((2 * (n + 1)) % 16);
        e.hi0 = a0 * CC;
        e.hi1 = a1 * CC;
        e.len = FRAME;
        exp_q.push_back(e);
    endtask

    task automatic check_frames(input string tag);
        frm_t e, o;
        int i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk($sformatf("%s_f%0d_missing", tag, i), 0, 1);
            end else begin
                o = obs_q.pop_front();
                chk($sformatf("%s_f%0d_led", tag, i), o.led, e.led);
                chk($sformatf("%s_f%0d_hi0", tag, i), o.hi0, e.hi0);
                chk($sformatf("%s_f%0d_hi1", tag, i), o.hi1, e.hi1);
                chk($sformatf("%s_f%0d_len", tag, i), o.len, e.len);
            end
            i++;
        end
        chk({tag, "_extra"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) start_playback = 1'b1;
        repeat (8) @(negedge clk);
        start_playback = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop_playback = 1'b1;
        repeat (8) @(negedge clk);
        stop_playback = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, input string tag);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, int'(obs_q.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, int'(busy === 1'b0), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start_playback = 1'b0;
        stop_playback = 1'b0;
        loop_en = 1'b0;
        fill(4'd2, 4'd5);
        repeat (4) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_led", int'(clr_led), 0);
        chk("rst_addr", int'(ram_rdaddr), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        pulse_stop();
        repeat (20) @(negedge clk);
        chk("idle_stop_busy", int'(busy), 0);
        chk("idle_stop_frames", obs_q.size(), 0);

        // Constant amplitudes, loop_en high.
        d0 = done_cnt;
        loop_en = 1'b1;
`ifdef PWM_PLAYBACK_LOOP_EN
        for (int n = 0; n < 9; n++) push_frm(n, 2, 5);
`else
        for (int n = 0; n < 8; n++) push_frm(n, 2, 5);
`endif
        pulse_start();
        wait_obs(1, 2 * FRAME, "a_first_frame");
`ifdef PWM_PLAYBACK_LOOP_EN
        wait_obs(8, 9 * FRAME, "a_reach_frame8");
        chk("a_no_done_on_wrap", done_cnt - d0, 0);
        chk("a_busy_on_wrap", int'(busy), 1);
        repeat (1000) @(negedge clk);
        pulse_stop();
`endif
        wait_idle(10 * FRAME, "a_idle");
        chk("a_done_once", done_cnt - d0, 1);
        chk("a_pwm_zero", int'(pwm_out), 0);
        check_frames("a");
        loop_en = 1'b0;

        // Extreme amplitudes and a stop during frame 3.
        fill(4'd0, 4'd8);
        d0 = done_cnt;
        for (int n = 0; n < 4; n++) push_frm(n, 0, 8);
        pulse_start();
        wait_obs(3, 5 * FRAME, "b_reach_frame3");
        repeat (2000) @(negedge clk);
        chk("b_pwm_mid", int'(pwm_out), 2);
        pulse_stop();
        wait_idle(3 * FRAME, "b_idle");
        chk("b_done_once", done_cnt - d0, 1);
        chk("b_pwm_zero", int'(pwm_out), 0);
        chk("b_addr_stop", int'(ram_rdaddr), 10);
        repeat (500) @(negedge clk);
        chk("b_addr_hold", int'(ram_rdaddr), 10);
        check_frames("b");

        // Re-start while busy, then async reset in frame 5.
        fill(4'd2, 4'd5);
        d0 = done_cnt;
        for (int n = 0; n < 5; n++) push_frm(n, 2, 5);
        pulse_start();
        wait_obs(1, 2 * FRAME, "c_first_frame");
        pulse_start();
        wait_obs(5, 6 * FRAME, "c_reach_frame5");
        repeat (1000) @(negedge clk);
        chk("c_busy_pre", int'(busy), 1);
        chk("c_pwm_pre", int'(pwm_out), 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("c_rst_pwm", int'(pwm_out), 0);
        chk("c_rst_busy", int'(busy), 0);
        chk("c_rst_done", int'(done), 0);
        chk("c_rst_led", int'(clr_led), 0);
        chk("c_rst_addr", int'(ram_rdaddr), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        chk("c_no_done", done_cnt - d0, 0);
        chk("c_wait_start", int'(busy), 0);
        check_frames("c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
